// File: rtl/addsub_arb_pkg.sv
// -----------------------------------------------------------------------------
// addsub_arb_pkg
// Shared types and helpers for the add/sub round-robin arbiter.
//   buf_state_t : state of the one-entry result buffer
//   id_width()  : width of a requester index for n requesters (at least 1)
//   N_MIN/N_MAX : supported requester-count range
// The result-record struct depends on the top-level M/N parameters, so it is
// declared inside addsub_rr_arbiter using id_width().
// -----------------------------------------------------------------------------
package addsub_arb_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prefixAddSub.sv
// -----------------------------------------------------------------------------
// prefixAddSub
// W-bit Kogge-Stone parallel-prefix adder/subtractor.
//   sum = a + (b ^ {W{sub}}) + cin  (mod 2^W)
// Ports:
//   a, b   in  W  operands
//   sub    in  1  invert b (subtract when combined with cin=1)
//   cin    in  1  carry into bit 0
//   sum    out W  result
//   cout   out 1  carry out of bit W-1
//   ovf    out 1  two's-complement overflow (carry into MSB xor carry out)
// -----------------------------------------------------------------------------
module prefixAddSub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int L = $clog2(W);

    logic [W-1:0] b_eff;
    logic [W:0]   carry;

    assign b_eff = b ^ {W{sub}};

    // One generate block per prefix level, each with its own (g,p) vectors,
    // so every level only depends on the level below it.
    for (genvar gk = 0; gk <= L; gk++) begin : gen_lvl
        logic [W-1:0] g_l;
        logic [W-1:0] p_l;
        if (gk == 0) begin : gen_base
            assign g_l = a & b_eff;
            assign p_l = a ^ b_eff;
        end else begin : gen_merge
            for (genvar gi = 0; gi < W; gi++) begin : gen_bit
                if (gi >= (1 << (gk - 1))) begin : gen_comb
                    assign g_l[gi] = gen_lvl[gk-1].g_l[gi]
                                   | (gen_lvl[gk-1].p_l[gi] & gen_lvl[gk-1].g_l[gi - (1 << (gk - 1))]);
                    assign p_l[gi] = gen_lvl[gk-1].p_l[gi] & gen_lvl[gk-1].p_l[gi - (1 << (gk - 1))];
                end else begin : gen_pass
                    assign g_l[gi] = gen_lvl[gk-1].g_l[gi];
                    assign p_l[gi] = gen_lvl[gk-1].p_l[gi];
                end
            end
        end
    end

    // After the last level, (g,p)[i] span bits i..0; fold cin in at the end.
    assign carry = {gen_lvl[L].g_l | (gen_lvl[L].p_l & {W{cin}}), cin};
    assign sum   = gen_lvl[0].p_l ^ carry[W-1:0];
    assign cout  = carry[W];
    assign ovf   = carry[W] ^ carry[W-1];

endmodule

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping modulo N.
// Ports:
//   req        in  N     request vector
//   ptr        in  ID_W  highest-priority index this cycle
//   grant      out N     one-hot grant (zero when no request)
//   grant_idx  out ID_W  index of the granted requester (0 when none)
//   any        out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_grant #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx[ID_W-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_rr_arbiter
// Shares one M-bit prefix adder/subtractor between N requesters. One request
// per cycle is picked round-robin, evaluated, and registered into a one-entry
// result buffer (latency 1, throughput 1/cycle when drained).
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_sub, req_cin     per-requester op (0 add / 1 sub) and carry/borrow in
//   req_x, req_y         packed operands, requester i at [i*M +: M]
//   req_lock             (ADDSUB_ARB_LOCK_EN only) hold priority after grant
//   rsp_valid/rsp_ready  result handshake
//   rsp_id, rsp_out      producing requester and result
//   rsp_cout             add: carry-out; sub: 1 = no borrow
//   rsp_v                two's-complement overflow
// Optional feature macro: ADDSUB_ARB_LOCK_EN
// -----------------------------------------------------------------------------
module addsub_rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int M = 32,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N-1:0]         req_sub,
    input  logic [N-1:0]         req_cin,
`ifdef ADDSUB_ARB_LOCK_EN
    input  logic [N-1:0]         req_lock,
`endif
    input  logic [N*M-1:0]       req_x,
    input  logic [N*M-1:0]       req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [M-1:0]         rsp_out,
    output logic                 rsp_cout,
    output logic                 rsp_v
);

    localparam int ID_W = id_width(N);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [M-1:0]    out;
        logic            cout;
        logic            v;
    } rsp_t;

    buf_state_t      state_reg, state_next;
    rsp_t            rsp_reg, rsp_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;
`ifdef ADDSUB_ARB_LOCK_EN
    logic            lock_active_reg, lock_active_next;
`endif

    logic [M-1:0]    x_arr [N];
    logic [M-1:0]    y_arr [N];

    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            accept;
    logic [ID_W-1:0] idx_inc;

    logic [M-1:0]    core_sum;
    logic            core_cout;
    logic            core_ovf;

    // Unpack the flat operand buses for indexed selection.
    for (genvar gi = 0; gi < N; gi++) begin : gen_unpack
        assign x_arr[gi] = req_x[gi*M +: M];
        assign y_arr[gi] = req_y[gi*M +: M];
    end

    rr_grant #(
        .N    (N),
        .ID_W (ID_W)
    ) u_grant (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign rsp_valid  = (state_reg == BUF_FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    // rst gates acceptance so no handshake completes while reset is held.
    assign accept     = can_accept && grant_any && !rst;
    assign req_ready  = accept ? grant : '0;

    // Subtract is x + ~y + 1 - borrow_in, so the core's carry-in is the
    // inverted borrow; its carry-out then reads as "no borrow".
    prefixAddSub #(
        .W (M)
    ) u_core (
        .a    (x_arr[grant_idx]),
        .b    (y_arr[grant_idx]),
        .sub  (req_sub[grant_idx]),
        .cin  (req_cin[grant_idx] ^ req_sub[grant_idx]),
        .sum  (core_sum),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    assign idx_inc = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);

    // Buffer FSM and result payload.
    always_comb begin
        state_next = state_reg;
        rsp_next   = rsp_reg;
        case (state_reg)
            BUF_EMPTY: begin
                if (accept) begin
                    state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (accept) begin
                    state_next = BUF_FULL;
                end else if (rsp_ready) begin
                    state_next = BUF_EMPTY;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
        if (accept) begin
            rsp_next.id   = grant_idx;
            rsp_next.out  = core_sum;
            rsp_next.cout = core_cout;
            rsp_next.v    = core_ovf;
        end
    end

    // Round-robin pointer.
`ifdef ADDSUB_ARB_LOCK_EN
    always_comb begin
        ptr_next         = ptr_reg;
        lock_active_next = lock_active_reg;
        if (accept) begin
            // A locked grant keeps the pointer on the winner.
            ptr_next         = req_lock[grant_idx] ? grant_idx : idx_inc;
            lock_active_next = req_lock[grant_idx];
        end else if (lock_active_reg && !req_valid[ptr_reg]) begin
            // Lock holder went away without another grant: move past it.
            ptr_next         = (ptr_reg == ID_W'(N - 1)) ? '0 : ptr_reg + ID_W'(1);
            lock_active_next = 1'b0;
        end
    end
`else
    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = idx_inc;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BUF_EMPTY;
            rsp_reg         <= '0;
            ptr_reg         <= '0;
`ifdef ADDSUB_ARB_LOCK_EN
            lock_active_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            rsp_reg         <= rsp_next;
            ptr_reg         <= ptr_next;
`ifdef ADDSUB_ARB_LOCK_EN
            lock_active_reg <= lock_active_next;
`endif
        end
    end

    assign rsp_id   = rsp_reg.id;
    assign rsp_out  = rsp_reg.out;
    assign rsp_cout = rsp_reg.cout;
    assign rsp_v    = rsp_reg.v;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_rr_arbiter
// Directed plus randomized stimulus for addsub_rr_arbiter (M=32, N=4),
// checked against an arithmetic/queue-free reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_addsub_rr_arbiter;

    localparam int M = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_sub;
    logic [N-1:0]   req_cin;
    logic [N*M-1:0] req_x;
    logic [N*M-1:0] req_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [M-1:0]   rsp_out;
    logic           rsp_cout;
    logic           rsp_v;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic        m_valid;
    int          m_id;
    logic [31:0] m_out;
    logic        m_cout;
    logic        m_v;
    int          m_ptr;

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_cin   (req_cin),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_cout  (rsp_cout),
        .rsp_v     (rsp_v)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic defined directly from integer semantics.
    function automatic void calc(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic c,
                                 output logic [31:0] o, output logic co, output logic vv);
        longint ux, uy, sx, sy, u, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u  = ux + uy + longint'(c);
            o  = u[31:0];
            co = u[32];
            sr = sx + sy + longint'(c);
        end else begin
            o  = x - y - {31'b0, c};
            co = (ux >= uy + longint'(c));
            sr = sx - sy - longint'(c);
        end
        vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic c);
        req_x[i*M +: M] = x;
        req_y[i*M +: M] = y;
        req_sub[i]      = s;
        req_cin[i]      = c;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_out   = '0;
        m_cout  = 1'b0;
        m_v     = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock: inputs already driven at a negedge. Checks req_ready before
    // the edge and the result buffer after it.
    task automatic step();
        int         g;
        logic       can;
        logic [3:0] exp_ready;
        #1;
        can = !m_valid || rsp_ready;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_ready = (can && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", {60'b0, req_ready}, {60'b0, exp_ready});
        @(posedge clk);
        if (can && g >= 0) begin
            calc(req_x[g*M +: M], req_y[g*M +: M], req_sub[g], req_cin[g], m_out, m_cout, m_v);
            m_valid = 1'b1;
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, m_valid});
        if (m_valid) begin
            chk("rsp_id",   {62'b0, rsp_id},   64'(m_id));
            chk("rsp_out",  {32'b0, rsp_out},  {32'b0, m_out});
            chk("rsp_cout", {63'b0, rsp_cout}, {63'b0, m_cout});
            chk("rsp_v",    {63'b0, rsp_v},    {63'b0, m_v});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'b0, rsp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_sub   = '0;
        req_cin   = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        model_reset();

        // Reset state.
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rsp_id",    {62'b0, rsp_id},    64'd0);
        chk("rst_rsp_out",   {32'b0, rsp_out},   64'd0);
        chk("rst_rsp_cout",  {63'b0, rsp_cout},  64'd0);
        chk("rst_rsp_v",     {63'b0, rsp_v},     64'd0);
        chk("rst_req_ready", {60'b0, req_ready}, 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // 1: requester 0 add with carry-in.
        set_op(0, 32'd5, 32'd3, 1'b0, 1'b1);
        req_valid = 4'b0001;
        step();
        chk("t1_out", {32'b0, rsp_out}, 64'd9);

        // 2: requester 2 add, signed overflow, then carry-out.
        set_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        req_valid = 4'b0100;
        step();
        chk("t2a_out", {32'b0, rsp_out}, 64'h8000_0000);
        chk("t2a_v",   {63'b0, rsp_v},   64'd1);
        set_op(2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step();
        chk("t2b_cout", {63'b0, rsp_cout}, 64'd1);

        // 3: requester 1 subtract with borrow, then signed overflow.
        set_op(1, 32'd3, 32'd5, 1'b1, 1'b0);
        req_valid = 4'b0010;
        step();
        chk("t3a_out", {32'b0, rsp_out}, 64'hFFFF_FFFE);
        set_op(1, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
        step();
        chk("t3b_out", {32'b0, rsp_out}, 64'h7FFF_FFFF);
        chk("t3b_v",   {63'b0, rsp_v},   64'd1);
        req_valid = '0;
        step();

        // 4: all requesting from a fresh pointer, no bubbles.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 100), 32'(i), 1'b0, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // 5: backpressure for 3 cycles, then drain and refill in one cycle.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();

        // 6: asynchronous reset while a result is held.
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("t6_req_ready", {60'b0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t6_first_grant", {60'b0, req_ready}, 64'd1);
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                set_op(i, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
